// File: rtl/beat_timing_gen_if.sv
// Beat-side bundle between the timing generator and the hardwired controller.
// instr_cnt_o is present only when INSTR_CNT_EN is defined.
interface beat_timing_gen_if;
    logic qd_i;
    logic dp_i;
    logic stop_i;
    logic short_i;
    logic long_i;
    logic w1_o;
    logic w2_o;
    logic w3_o;
    logic t1_o;
    logic t2_o;
    logic t3_o;
    logic running_o;
`ifdef INSTR_CNT_EN
    logic [15:0] instr_cnt_o;

    modport slave (
        input  qd_i, dp_i, stop_i, short_i, long_i,
        output w1_o, w2_o, w3_o, t1_o, t2_o, t3_o,
        output running_o, instr_cnt_o
    );

    modport master (
        output qd_i, dp_i, stop_i, short_i, long_i,
        input  w1_o, w2_o, w3_o, t1_o, t2_o, t3_o,
        input  running_o, instr_cnt_o
    );
`else
    modport slave (
        input  qd_i, dp_i, stop_i, short_i, long_i,
        output w1_o, w2_o, w3_o, t1_o, t2_o, t3_o,
        output running_o
    );

    modport master (
        output qd_i, dp_i, stop_i, short_i, long_i,
        input  w1_o, w2_o, w3_o, t1_o, t2_o, t3_o,
        input  running_o
    );
`endif
endinterface

// File: rtl/beat_timing_gen.sv
// Machine-beat (W1..W3) and phase (T1..T3) generator for the controller.
// Optional macro INSTR_CNT_EN adds a 16-bit instruction counter.
module beat_timing_gen #(
    parameter int CLK_DIV = 1
) (
    input logic clk,
    input logic clr,
    beat_timing_gen_if.slave bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    localparam logic [2:0] B_W1 = 3'b001;
    localparam logic [2:0] B_W2 = 3'b010;
    localparam logic [2:0] B_W3 = 3'b100;
    localparam logic [2:0] P_T1 = 3'b001;
    localparam logic [2:0] P_T2 = 3'b010;
    localparam logic [2:0] P_T3 = 3'b100;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q;
    logic [2:0]    w_q;
    logic [2:0]    t_q;
    logic [PW-1:0] pre_q;
    logic          qd_q;
`ifdef INSTR_CNT_EN
    logic [15:0]   cnt_q;
`endif

    logic [2:0] w_d;
    logic       end_d;
    logic       halt_d;
    logic       phase_end;
    logic       start;

    assign phase_end = (pre_q == PRE_LAST);
    assign start     = bus.qd_i & ~qd_q;

    // Next beat and instruction-end decision for the current beat's T3.
    always_comb begin
        w_d   = B_W1;
        end_d = 1'b1;
        unique case (1'b1)
            w_q[0]: begin
                end_d = bus.short_i;
                w_d   = bus.short_i ? B_W1 : B_W2;
            end
            w_q[1]: begin
                end_d = ~bus.long_i;
                w_d   = bus.long_i ? B_W3 : B_W1;
            end
            w_q[2]: begin
                end_d = 1'b1;
                w_d   = B_W1;
            end
            default: ;
        endcase
        halt_d = bus.stop_i | (end_d & bus.dp_i);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            w_q     <= B_W1;
            t_q     <= 3'b000;
            pre_q   <= '0;
            qd_q    <= 1'b1;
`ifdef INSTR_CNT_EN
            cnt_q   <= 16'h0000;
`endif
        end else begin
            qd_q <= bus.qd_i;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        t_q     <= P_T1;
                        pre_q   <= '0;
                    end
                end
                RUN: begin
                    if (!phase_end) begin
                        pre_q <= pre_q + 1'b1;
                    end else begin
                        pre_q <= '0;
                        unique case (1'b1)
                            t_q[0]: t_q <= P_T2;
                            t_q[1]: t_q <= P_T3;
                            t_q[2]: begin
                                w_q <= w_d;
                                t_q <= halt_d ? 3'b000 : P_T1;
                                if (halt_d) state_q <= IDLE;
`ifdef INSTR_CNT_EN
                                if (end_d) cnt_q <= cnt_q + 16'h0001;
`endif
                            end
                            default: t_q <= P_T1;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.w1_o      = w_q[0];
    assign bus.w2_o      = w_q[1];
    assign bus.w3_o      = w_q[2];
    assign bus.t1_o      = t_q[0];
    assign bus.t2_o      = t_q[1];
    assign bus.t3_o      = t_q[2];
    assign bus.running_o = (state_q == RUN);
`ifdef INSTR_CNT_EN
    assign bus.instr_cnt_o = cnt_q;
`endif

endmodule
